// File: rtl/axi4lite_cmd_sequencer.sv
// axi4lite_cmd_sequencer
// Buffers AXI4-Lite register commands in a small FIFO and issues them to the
// master one at a time as single-cycle start pulses. Each completion, including
// read data, is returned on a valid/ready response port.
// Optional build macro: AXI4LITE_CMDSEQ_TIMEOUT_EN adds a WAIT timeout.
// When it fires, the command completes with rsp_err=1 and rsp_data=0.
module axi4lite_cmd_sequencer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    output logic                   m_start_write,
    output logic                   m_start_read,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    input  logic                   m_done,
    input  logic [DATA_WIDTH-1:0]  m_rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [ADDR_WIDTH-1:0]  rsp_addr,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ready_en_q, ready_en_d;
    logic                    done_q, done_d;
    logic                    act_write_q, act_write_d;
    logic [ADDR_WIDTH-1:0]   act_addr_q, act_addr_d;
    logic [DATA_WIDTH-1:0]   act_wdata_q, act_wdata_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
    logic [7:0]              tmo_cnt_q, tmo_cnt_d;
    logic                    rsp_err_q, rsp_err_d;
`endif

    logic [ENT_W-1:0]        fifo_mem [DEPTH];
    logic [ENT_W-1:0]        head;
    logic                    head_write;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]   head_wdata;
    logic                    push;
    logic                    pop;
    logic                    done_rise;

    assign head       = fifo_mem[rd_ptr_q];
    assign head_write = head[ENT_W-1];
    assign head_addr  = head[ENT_W-2 -: ADDR_WIDTH];
    assign head_wdata = head[DATA_WIDTH-1:0];

    // The entry leaves the FIFO on the ISSUE cycle; it was already copied into
    // the active registers on the way into ISSUE.
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_ISSUE);
    // A done level still high from the previous transaction never counts.
    assign done_rise = m_done && !done_q;

    // FIFO pointers and occupancy; simultaneous push and pop keep the level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage: payload only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // Sequencer next-state, active command capture and response capture
    always_comb begin
        state_d     = state_q;
        ready_en_d  = 1'b1;
        done_d      = m_done;
        act_write_d = act_write_q;
        act_addr_d  = act_addr_q;
        act_wdata_d = act_wdata_q;
        rsp_write_d = rsp_write_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    // Load the head now so the start pulse and address
                    // come straight from registers during ISSUE.
                    act_write_d = head_write;
                    act_addr_d  = head_addr;
                    act_wdata_d = head_wdata;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                if (done_rise) begin
                    rsp_write_d = act_write_q;
                    rsp_addr_d  = act_addr_q;
                    rsp_data_d  = act_write_q ? act_wdata_q : m_rdata;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
                // The counter reaches 255 this cycle; a completion in the
                // same cycle has already won above.
                else if (tmo_cnt_q == 8'd254) begin
                    rsp_write_d = act_write_q;
                    rsp_addr_d  = act_addr_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers; async reset discards all queued work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_en_q  <= 1'b0;
            done_q      <= 1'b0;
            act_write_q <= 1'b0;
            act_addr_q  <= '0;
            act_wdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_en_q  <= ready_en_d;
            done_q      <= done_d;
            act_write_q <= act_write_d;
            act_addr_q  <= act_addr_d;
            act_wdata_q <= act_wdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // ready_en_q holds cmd_ready low through reset and releases it one edge later.
    assign cmd_ready     = ready_en_q && (level_q != LVL_FULL);
    assign m_start_write = (state_q == S_ISSUE) &&  act_write_q;
    assign m_start_read  = (state_q == S_ISSUE) && !act_write_q;
    assign m_addr        = act_addr_q;
    assign m_wdata       = act_wdata_q;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_write     = rsp_write_q;
    assign rsp_addr      = rsp_addr_q;
    assign rsp_data      = rsp_data_q;
`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
    assign rsp_err       = rsp_err_q;
`else
    assign rsp_err       = 1'b0;
`endif
    assign busy          = (state_q != S_IDLE) || (level_q != '0);
    assign level         = level_q;

endmodule

// File: tb/tb_axi4lite_cmd_sequencer.sv
// Testbench for axi4lite_cmd_sequencer: directed scenarios plus a randomized
// phase. Expected starts and responses are queued when commands are accepted
// and checked by an independent monitor.
module tb_axi4lite_cmd_sequencer;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          m_start_write, m_start_read;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_done;
    logic [DW-1:0] m_rdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [LW-1:0] level;

    axi4lite_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .m_start_write(m_start_write), .m_start_read(m_start_read),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          err;
    } exp_t;

    exp_t          exp_rsp[$];
    exp_t          exp_start[$];
    logic [DW-1:0] ref_regs [4];
    logic [DW-1:0] mst_regs [4];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            rsp_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: commands complete in acceptance order; a read returns the
    // last value written to that address.
    task automatic push_exp(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic tmo);
        exp_t r;
        exp_t s;
        r.w = w; r.a = a; r.err = tmo;
        if (tmo)    r.d = '0;
        else if (w) r.d = d;
        else        r.d = ref_regs[a];
        if (w && !tmo) ref_regs[a] = d;
        exp_rsp.push_back(r);
        s.w = w; s.a = a; s.d = d; s.err = 1'b0;
        exp_start.push_back(s);
    endtask

    // Offer one command and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic tmo);
        int b;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        b = 0;
        while (!cmd_ready && b < 500) begin tick(); b++; end
        if (b >= 500) begin
            check("send_accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        push_exp(w, a, d, tmo);
        cmd_valid = 1'b0;
    endtask

    // Slave/master stand-in: wait for a start, then produce a done rising edge.
    task automatic serve_one(input logic keep_high, input int dly);
        int            b;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        b = 0;
        while (!(m_start_write || m_start_read) && b < 400) begin tick(); b++; end
        if (b >= 400) begin
            check("serve_start_timeout", 32'(m_start_write | m_start_read), 32'd1);
            return;
        end
        w = m_start_write; a = m_addr; wd = m_wdata;
        tick();
        if (m_done) begin m_done = 1'b0; tick(); end
        repeat (dly) tick();
        if (w) begin mst_regs[a] = wd; m_rdata = DW'($urandom); end
        else   m_rdata = mst_regs[a];
        m_done = 1'b1;
        tick();
        if (!keep_high) m_done = 1'b0;
    endtask

    // Monitor: checks every start pulse and every response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_start_write || m_start_read) begin
                    check("start_exclusive", 32'(m_start_write & m_start_read), 32'd0);
                    check("start_pending", 32'(exp_start.size() != 0), 32'd1);
                    if (exp_start.size() != 0) begin
                        e = exp_start.pop_front();
                        check("start_type", 32'(m_start_write), 32'(e.w));
                        check("start_addr", 32'(m_addr), 32'(e.a));
                        if (e.w) check("start_wdata", 32'(m_wdata), 32'(e.d));
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_seen++;
                    check("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
                    if (exp_rsp.size() != 0) begin
                        e = exp_rsp.pop_front();
                        check("rsp_write", 32'(rsp_write), 32'(e.w));
                        check("rsp_addr", 32'(rsp_addr), 32'(e.a));
                        check("rsp_data", 32'(rsp_data), 32'(e.d));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic          fw [6];
        logic [AW-1:0] fa [6];
        logic [DW-1:0] fd [6];
        logic [AW+DW+1:0] snap;
        int acc, idx, bad, starts, cyc, target;
        logic rdy;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        m_done = 1'b0; m_rdata = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ref_regs[i] = DW'(i * 17 + 3);
            mst_regs[i] = DW'(i * 17 + 3);
        end

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_outputs", 32'({m_start_write, m_start_read, m_addr, m_wdata, rsp_valid,
                                  rsp_write, rsp_addr, rsp_data, rsp_err, busy, level}), 32'd0);
        rst = 1'b0;
        check("ready_before_edge", 32'(cmd_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(cmd_ready), 32'd1);

        // Write then read with start and response latency
        send(1'b1, 2'd1, 8'h04, 1'b0);
        check("lat_no_start_yet", 32'(m_start_write | m_start_read), 32'd0);
        tick();
        check("lat_start_write", 32'(m_start_write), 32'd1);
        serve_one(1'b0, 2);
        check("rsp_valid_after_done", 32'(rsp_valid), 32'd1);
        send(1'b0, 2'd1, 8'h00, 1'b0);
        tick();
        check("lat_start_read", 32'(m_start_read), 32'd1);
        serve_one(1'b0, 0);
        check("wr_rd_data", 32'(rsp_data), 32'h04);
        repeat (3) tick();

        // FIFO full with responses held off
        fw[0] = 1'b1; fa[0] = 2'd0; fd[0] = 8'h77;
        for (int i = 1; i < 6; i++) begin
            fw[i] = 1'($urandom_range(0, 1)); fa[i] = AW'($urandom_range(0, 3)); fd[i] = DW'($urandom);
        end
        rsp_ready = 1'b0; acc = 0; idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                cmd_valid = 1'b1; cmd_write = fw[idx]; cmd_addr = fa[idx]; cmd_wdata = fd[idx];
            end
            rdy = cmd_ready;
            tick();
            if (idx < 6 && rdy) begin
                push_exp(fw[idx], fa[idx], fd[idx], 1'b0);
                idx++; acc++;
            end
        end
        cmd_valid = 1'b0;
        check("full_accepted", 32'(acc), 32'd5);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        rsp_ready = 1'b1;
        mst_regs[0] = 8'h77;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        for (int i = 0; i < 4; i++) serve_one(1'b0, $urandom_range(0, 3));
        repeat (3) tick();
        check("full_drained_level", 32'(level), 32'd0);
        check("full_drained_busy", 32'(busy), 32'd0);

        // Stale done level across ISSUE
        send(1'b1, 2'd2, 8'hA5, 1'b0);
        serve_one(1'b1, 1);
        tick();
        send(1'b0, 2'd2, 8'h00, 1'b0);
        cyc = 0;
        while (!m_start_read && cyc < 20) begin tick(); cyc++; end
        repeat (5) tick();
        check("stale_no_rsp", 32'(rsp_valid), 32'd0);
        m_done = 1'b0;
        tick();
        m_rdata = 8'hA5;
        m_done = 1'b1;
        tick();
        check("stale_rsp_valid", 32'(rsp_valid), 32'd1);
        check("stale_rsp_data", 32'(rsp_data), 32'hA5);
        m_done = 1'b0;
        repeat (2) tick();

        // Response backpressure
        rsp_ready = 1'b0;
        send(1'b1, 2'd0, 8'h5A, 1'b0);
        send(1'b0, 2'd3, 8'h00, 1'b0);
        serve_one(1'b0, 1);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        snap = {rsp_write, rsp_addr, rsp_data, rsp_err};
        bad = 0; starts = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({rsp_valid, rsp_write, rsp_addr, rsp_data, rsp_err} !== {1'b1, snap}) bad++;
            if (m_start_write || m_start_read) starts++;
        end
        check("bp_rsp_stable", 32'(bad), 32'd0);
        check("bp_no_start", 32'(starts), 32'd0);
        rsp_ready = 1'b1;
        tick();
        check("bp_start_n1", 32'(m_start_write | m_start_read), 32'd0);
        tick();
        check("bp_start_n2", 32'(m_start_read), 32'd1);
        serve_one(1'b0, 0);
        repeat (2) tick();

        // Reset while waiting with three commands queued
        for (int i = 0; i < 4; i++) send(1'b0, AW'($urandom_range(0, 3)), 8'h00, 1'b0);
        repeat (3) tick();
        check("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        #1;
        check("rst_async_starts", 32'({m_start_write, m_start_read}), 32'd0);
        check("rst_async_level", 32'(level), 32'd0);
        check("rst_async_outputs", 32'({m_addr, m_wdata, rsp_valid, rsp_data, busy, cmd_ready}), 32'd0);
        exp_rsp.delete();
        exp_start.delete();
        repeat (2) tick();
        rst = 1'b0;
        starts = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_start_write || m_start_read) starts++;
        end
        check("post_rst_no_start", 32'(starts), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

`ifdef AXI4LITE_CMDSEQ_TIMEOUT_EN
        // Timeout with done held low, then a normal command
        m_done = 1'b0;
        send(1'b0, 2'd3, 8'h00, 1'b1);
        send(1'b1, 2'd2, 8'h3C, 1'b0);
        cyc = 0;
        while (!m_start_read && cyc < 20) begin tick(); cyc++; end
        cyc = 0;
        while (!rsp_valid && cyc < 400) begin tick(); cyc++; end
        check("tmo_cycles", 32'(cyc), 32'd256);
        check("tmo_err", 32'(rsp_err), 32'd1);
        check("tmo_data", 32'(rsp_data), 32'd0);
        serve_one(1'b0, 1);
        check("tmo_next_err", 32'(rsp_err), 32'd0);
        repeat (2) tick();
`endif

        // Randomized traffic with random backpressure and done behaviour
        target = rsp_seen + 40;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom), 1'b0);
                end
            end
            begin
                for (int n = 0; n < 40; n++) serve_one(1'($urandom_range(0, 1)), $urandom_range(0, 4));
            end
            begin
                cyc = 0;
                while (rsp_seen < target && cyc < 20000) begin
                    tick();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                rsp_ready = 1'b1;
            end
        join
        m_done = 1'b0;
        repeat (5) tick();
        check("rand_rsp_count", 32'(rsp_seen), 32'(target));
        check("drain_rsp_queue", 32'(exp_rsp.size()), 32'd0);
        check("drain_start_queue", 32'(exp_start.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
